// File: rtl/gray_bin_conv_pipe_if.sv
// Handshake bundle for gray_bin_conv_pipe: input word/mode with valid/ready,
// and the tagged result with valid/ready plus the delivered-result counter.
interface gray_bin_conv_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
    logic             out_adj_err;
    logic [CNT_W-1:0] out_cnt;

    // master: the environment around the converter (source and sink)
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode, out_adj_err, out_cnt
    );

    // slave: the converter itself
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode, out_adj_err, out_cnt
    );
endinterface

// File: rtl/gray_bin_conv_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready on both sides.
// Optional adjacency checking of Gray inputs: define GRAY_CONV_ADJ_CHECK_EN.
module gray_bin_conv_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gray_bin_conv_pipe_if.slave  bus
);

    logic [WIDTH-1:0]  conv_data;
    logic              adj_in;
    logic              accept;

    logic [STAGES-1:0] st_vld;
    logic [STAGES-1:0] st_mode;
    logic [STAGES-1:0] st_adj;
    logic [WIDTH-1:0]  st_data [STAGES];
    logic [STAGES-1:0] st_load;

    logic [CNT_W-1:0]  cnt;

    // Gray->binary is a running XOR from the MSB down; binary->Gray is one shift.
    always_comb begin
        logic acc;
        acc       = 1'b0;
        conv_data = '0;
        if (bus.in_mode) begin
            conv_data = bus.in_data ^ (bus.in_data >> 1);
        end else begin
            for (int i = WIDTH-1; i >= 0; i--) begin
                acc          = acc ^ bus.in_data[i];
                conv_data[i] = acc;
            end
        end
    end

    // A stage may load when empty or when everything downstream can move;
    // may_drain carries "stage k advances" down the chain without bubbles.
    always_comb begin
        logic may_drain;
        may_drain = bus.out_ready;
        st_load   = '0;
        for (int k = STAGES-1; k >= 0; k--) begin
            st_load[k] = !st_vld[k] || may_drain;
            may_drain  = may_drain || !st_vld[k];
        end
    end

    assign bus.in_ready = st_load[0];
    assign accept       = bus.in_valid && st_load[0];

`ifdef GRAY_CONV_ADJ_CHECK_EN
    logic [WIDTH-1:0] last_gray;
    logic             have_last;
    logic [WIDTH-1:0] gray_diff;
    logic             one_apart;

    assign gray_diff = bus.in_data ^ last_gray;
    // exactly one bit set: nonzero and clearing the lowest set bit leaves zero
    assign one_apart = (gray_diff != '0) && ((gray_diff & (gray_diff - WIDTH'(1))) == '0);
    assign adj_in    = !bus.in_mode && have_last && !one_apart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gray <= '0;
            have_last <= 1'b0;
        end else if (accept && !bus.in_mode) begin
            last_gray <= bus.in_data;
            have_last <= 1'b1;
        end
    end
`else
    assign adj_in = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_vld  <= '0;
            st_mode <= '0;
            st_adj  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st_data[k] <= '0;
            end
        end else begin
            if (st_load[0]) begin
                st_vld[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    st_data[0] <= conv_data;
                    st_mode[0] <= bus.in_mode;
                    st_adj[0]  <= adj_in;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (st_load[k]) begin
                    st_vld[k] <= st_vld[k-1];
                    if (st_vld[k-1]) begin
                        st_data[k] <= st_data[k-1];
                        st_mode[k] <= st_mode[k-1];
                        st_adj[k]  <= st_adj[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (st_vld[STAGES-1] && bus.out_ready) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid   = st_vld[STAGES-1];
    assign bus.out_data    = st_data[STAGES-1];
    assign bus.out_mode    = st_mode[STAGES-1];
    assign bus.out_adj_err = st_adj[STAGES-1];
    assign bus.out_cnt     = cnt;

endmodule
